// File: rtl/r4u1_bf2_two_pkg.sv
// r4u1_bf2_two_pkg: shared widths, types and arithmetic helpers for the radix-2² stage II butterfly
package r4u1_bf2_two_pkg;
  localparam int MAN_WIDTH = 16;
  localparam int EXP_WIDTH = 6;
  localparam int MAX_M = 8;
  localparam int PW = $clog2(MAX_M);
  localparam int AW = MAN_WIDTH + 2;
  typedef logic signed [MAN_WIDTH-1:0] man_t;
  typedef logic signed [EXP_WIDTH-1:0] exp_t;
  typedef logic signed [AW-1:0] acc_t;
  typedef logic [PW:0] mcnt_t;
  typedef enum logic {FILL, BFLY} state_t;
  localparam acc_t MAN_MAX = acc_t'((1 << (MAN_WIDTH - 1)) - 1);
  localparam acc_t MAN_MIN = -MAN_MAX - acc_t'(1);
  function automatic mcnt_t m_decode(input logic [3:0] ldn);
    return (ldn >= 4'd4 && ldn <= 4'd10 && !ldn[0]) ? mcnt_t'(4) : mcnt_t'(MAX_M);
  endfunction
  // Right shift rounding half away from zero, done on the magnitude.
  function automatic acc_t sym_shr(input acc_t x, input int sh);
    acc_t m, r;
    if (sh <= 0) return x;
    m = (x < 0) ? -x : x;
    r = (m + (acc_t'(1) << (sh - 1))) >> sh;
    return (x < 0) ? -r : r;
  endfunction
  function automatic man_t sat(input acc_t x);
    return (x > MAN_MAX) ? man_t'(MAN_MAX) : (x < MAN_MIN) ? man_t'(MAN_MIN) : man_t'(x);
  endfunction
endpackage

// File: rtl/r4u1_bf2_two_align.sv
// bfp_align_bf2: block-floating-point exponent alignment, radix-2 add/sub and overflow rescale
module bfp_align_bf2 import r4u1_bf2_two_pkg::*; (
  input  man_t a_re_i,
  input  man_t a_im_i,
  input  exp_t a_exp_i,
  input  man_t b_re_i,
  input  man_t b_im_i,
  input  exp_t b_exp_i,
  output man_t s_re_o,
  output man_t s_im_o,
  output exp_t s_exp_o,
  output man_t d_re_o,
  output man_t d_im_o,
  output exp_t d_exp_o
);
  logic signed [EXP_WIDTH:0] ed;
  logic [EXP_WIDTH:0] sh;
  logic a_sm, zap, s_ov, d_ov;
  exp_t e;
  acc_t ar, ai, br, bi, sr, si, dr, di;
  always_comb begin
    ed = {a_exp_i[EXP_WIDTH-1], a_exp_i} - {b_exp_i[EXP_WIDTH-1], b_exp_i};
    a_sm = ed[EXP_WIDTH];
    sh = a_sm ? -ed : ed;
    zap = int'(sh) >= MAN_WIDTH;
    e = a_sm ? b_exp_i : a_exp_i;
    ar = (a_sm && zap) ? '0 : a_sm ? sym_shr(acc_t'(a_re_i), int'(sh)) : acc_t'(a_re_i);
    ai = (a_sm && zap) ? '0 : a_sm ? sym_shr(acc_t'(a_im_i), int'(sh)) : acc_t'(a_im_i);
    br = (!a_sm && zap) ? '0 : !a_sm ? sym_shr(acc_t'(b_re_i), int'(sh)) : acc_t'(b_re_i);
    bi = (!a_sm && zap) ? '0 : !a_sm ? sym_shr(acc_t'(b_im_i), int'(sh)) : acc_t'(b_im_i);
    sr = ar + br;
    si = ai + bi;
    dr = ar - br;
    di = ai - bi;
    s_ov = sr > MAN_MAX || sr < -MAN_MAX || si > MAN_MAX || si < -MAN_MAX;
    d_ov = dr > MAN_MAX || dr < -MAN_MAX || di > MAN_MAX || di < -MAN_MAX;
    s_re_o = sat(s_ov ? sym_shr(sr, 1) : sr);
    s_im_o = sat(s_ov ? sym_shr(si, 1) : si);
    s_exp_o = s_ov ? e + exp_t'(1) : e;
    d_re_o = sat(d_ov ? sym_shr(dr, 1) : dr);
    d_im_o = sat(d_ov ? sym_shr(di, 1) : di);
    d_exp_o = d_ov ? e + exp_t'(1) : e;
  end
endmodule

// File: rtl/r4u1_bf2_two.sv
// r4u1_bf2_two: radix-2² SDF butterfly stage II with trivial -j rotation and delay-M feedback buffer
module r4u1_bf2_two import r4u1_bf2_two_pkg::*; (
  input  logic                 clk_sys,
  input  logic                 rst_sys,
  input  logic                 block_sync_i,
  input  logic                 stage_sync_i,
  input  logic                 data_val_i,
  input  logic [MAN_WIDTH-1:0] data_real_i,
  input  logic [MAN_WIDTH-1:0] data_imag_i,
  input  logic [EXP_WIDTH-1:0] data_exp_i,
  input  logic                 k1_i,
  input  logic [3:0]           ldn_rg_i,
  output logic                 block_sync_o,
  output logic                 next_sync_o,
  output logic                 data_val_o,
  output logic [MAN_WIDTH-1:0] data_real_o,
  output logic [MAN_WIDTH-1:0] data_imag_o,
  output logic [EXP_WIDTH-1:0] data_exp_o,
  output logic                 k1_o,
  output logic                 k2_o
);
  logic v1_q, ss1_q, bs1_q, k11_q;
  man_t re1_q, im1_q;
  exp_t e1_q;
  state_t st_q, st_d, st;
  logic [PW-1:0] pos_q, pos_d, dr_q, dr_d, p, last;
  logic pend_q, pend_d, k1r_q, k1r_d, k1d_q, k1d_d, bsf_q, bsf_d;
  logic sync, k1e, sum_v, drain;
  man_t rre, rim, s_re, s_im, d_re, d_im;
  exp_t s_exp, d_exp;
  man_t mem_re [MAX_M];
  man_t mem_im [MAX_M];
  exp_t mem_exp [MAX_M];
  logic val_d, bso_d, ns_d, k1o_d, k2o_d, val_q, bso_q, ns_q, k1o_q, k2o_q;
  man_t ore_d, oim_d, ore_q, oim_q;
  exp_t oexp_d, oexp_q;
  bfp_align_bf2 u_align (
    .a_re_i(mem_re[p]), .a_im_i(mem_im[p]), .a_exp_i(mem_exp[p]),
    .b_re_i(rre), .b_im_i(rim), .b_exp_i(e1_q),
    .s_re_o(s_re), .s_im_o(s_im), .s_exp_o(s_exp),
    .d_re_o(d_re), .d_im_o(d_im), .d_exp_o(d_exp)
  );
  always_comb begin
    last = PW'(m_decode(ldn_rg_i) - 1'b1);
    sync = v1_q & ss1_q;
    p = sync ? '0 : pos_q;
    st = sync ? FILL : st_q;
    k1e = (p == '0) ? k11_q : k1r_q;
    rre = k1e ? im1_q : re1_q;
    rim = k1e ? sat(-acc_t'(re1_q)) : im1_q;
    sum_v = v1_q & (st == BFLY);
    drain = pend_q & ~sum_v & ~sync;
    pos_d = v1_q ? ((p == last) ? '0 : p + 1'b1) : pos_q;
    st_d = (v1_q && p == last) ? ((st == FILL) ? BFLY : FILL) : st;
    k1r_d = (v1_q && p == '0) ? k11_q : k1r_q;
    pend_d = pend_q;
    dr_d = dr_q;
    k1d_d = k1d_q;
    // The last butterfly arms the drain; a segment restart abandons it.
    if (sync) pend_d = 1'b0;
    else if (sum_v && p == last) begin
      pend_d = 1'b1;
      dr_d = '0;
      k1d_d = k1e;
    end else if (drain) begin
      pend_d = dr_q != last;
      dr_d = (dr_q == last) ? '0 : dr_q + 1'b1;
    end
    val_d = sum_v | drain;
    ore_d = sum_v ? s_re : drain ? mem_re[dr_q] : '0;
    oim_d = sum_v ? s_im : drain ? mem_im[dr_q] : '0;
    oexp_d = sum_v ? s_exp : drain ? mem_exp[dr_q] : '0;
    ns_d = sum_v ? (p == '0) : drain & (dr_q == '0);
    k1o_d = sum_v ? k1e : drain & k1d_q;
    k2o_d = drain;
    bso_d = sum_v & (p == '0) & bsf_q;
    bsf_d = (ss1_q & bs1_q) | (bsf_q & ~bso_d);
  end
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      {v1_q, ss1_q, bs1_q, k11_q} <= '0;
      re1_q <= '0;
      im1_q <= '0;
      e1_q <= '0;
      st_q <= FILL;
      pos_q <= '0;
      dr_q <= '0;
      {pend_q, k1r_q, k1d_q, bsf_q} <= '0;
      {val_q, bso_q, ns_q, k1o_q, k2o_q} <= '0;
      ore_q <= '0;
      oim_q <= '0;
      oexp_q <= '0;
    end else begin
      {v1_q, ss1_q, bs1_q, k11_q} <= {data_val_i, stage_sync_i, block_sync_i, k1_i};
      re1_q <= data_real_i;
      im1_q <= data_imag_i;
      e1_q <= data_exp_i;
      st_q <= st_d;
      pos_q <= pos_d;
      dr_q <= dr_d;
      {pend_q, k1r_q, k1d_q, bsf_q} <= {pend_d, k1r_d, k1d_d, bsf_d};
      {val_q, bso_q, ns_q, k1o_q, k2o_q} <= {val_d, bso_d, ns_d, k1o_d, k2o_d};
      ore_q <= ore_d;
      oim_q <= oim_d;
      oexp_q <= oexp_d;
    end
  end
  // Nonblocking write gives read-before-write against the concurrent drain read.
  always_ff @(posedge clk_sys) begin
    if (v1_q) begin
      mem_re[p] <= sum_v ? d_re : rre;
      mem_im[p] <= sum_v ? d_im : rim;
      mem_exp[p] <= sum_v ? d_exp : e1_q;
    end
  end
  assign block_sync_o = bso_q;
  assign next_sync_o = ns_q;
  assign data_val_o = val_q;
  assign data_real_o = ore_q;
  assign data_imag_o = oim_q;
  assign data_exp_o = oexp_q;
  assign k1_o = k1o_q;
  assign k2_o = k2o_q;
endmodule

// File: tb/tb_r4u1_bf2_two.sv
// tb_r4u1_bf2_two: directed self-checking bench for the radix-2² stage II butterfly
module tb_r4u1_bf2_two;
  import r4u1_bf2_two_pkg::*;
  localparam int VW = 5 + 2 * MAN_WIDTH + EXP_WIDTH;
  logic clk_sys = 1'b0, rst_sys = 1'b1;
  logic block_sync_i = 1'b0, stage_sync_i = 1'b0, data_val_i = 1'b0, k1_i = 1'b0;
  logic [MAN_WIDTH-1:0] data_real_i = '0, data_imag_i = '0;
  logic [EXP_WIDTH-1:0] data_exp_i = '0;
  logic [3:0] ldn_rg_i = 4'd4;
  logic block_sync_o, next_sync_o, data_val_o, k1_o, k2_o;
  logic [MAN_WIDTH-1:0] data_real_o, data_imag_o;
  logic [EXP_WIDTH-1:0] data_exp_o;
  int total = 0, bad = 0;
  r4u1_bf2_two dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .block_sync_i(block_sync_i), .stage_sync_i(stage_sync_i),
    .data_val_i(data_val_i), .data_real_i(data_real_i), .data_imag_i(data_imag_i),
    .data_exp_i(data_exp_i), .k1_i(k1_i), .ldn_rg_i(ldn_rg_i), .block_sync_o(block_sync_o),
    .next_sync_o(next_sync_o), .data_val_o(data_val_o), .data_real_o(data_real_o),
    .data_imag_o(data_imag_o), .data_exp_o(data_exp_o), .k1_o(k1_o), .k2_o(k2_o)
  );
  always #5 clk_sys = ~clk_sys;
  function automatic logic [VW-1:0] ev(input logic v, bs, ns, k1, k2, input int re, im, e);
    return {v, bs, ns, k1, k2, MAN_WIDTH'(re), MAN_WIDTH'(im), EXP_WIDTH'(e)};
  endfunction
  task automatic drv(input logic v, ss, bs, k1, input int re, im, e);
    data_val_i = v;
    stage_sync_i = ss;
    block_sync_i = bs;
    k1_i = k1;
    data_real_i = MAN_WIDTH'(re);
    data_imag_i = MAN_WIDTH'(im);
    data_exp_i = EXP_WIDTH'(e);
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string tag, input logic [VW-1:0] want);
    logic [VW-1:0] got;
    got = {data_val_o, block_sync_o, next_sync_o, k1_o, k2_o, data_real_o, data_imag_o, data_exp_o};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got={v,bs,ns,k1,k2,re,im,exp}=%h want=%h", tag, got, want);
    end
  endtask
  // x(n) = (100n, 0), M = 4: sums 400..1000 then four -400 differences
  task automatic scen1(input string tag);
    logic [VW-1:0] w;
    for (int j = 0; j < 14; j++) begin
      if (j < 8) drv(1'b1, j == 0, 1'b0, 1'b0, 100 * j, 0, 0);
      else drv(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      if (j < 5) w = '0;
      else if (j < 9) w = ev(1'b1, 1'b0, j == 5, 1'b0, 1'b0, 400 + 200 * (j - 5), 0, 0);
      else if (j < 13) w = ev(1'b1, 1'b0, j == 9, 1'b0, 1'b1, -400, 0, 0);
      else w = '0;
      chk(tag, w);
    end
  endtask
  // Four copies of a, four of b (M = 4), then the expected sum run and difference run.
  task automatic run_m4(input string tag, input int ar, ai, ae, input logic ak1,
                        input int br, bi, be, input logic bk1,
                        input int sr, si, se, dr, di, de, input logic k1o);
    logic [VW-1:0] w;
    for (int j = 0; j < 14; j++) begin
      if (j < 4) drv(1'b1, j == 0, 1'b0, ak1, ar, ai, ae);
      else if (j < 8) drv(1'b1, 1'b0, 1'b0, bk1, br, bi, be);
      else drv(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      if (j < 5) w = '0;
      else if (j < 9) w = ev(1'b1, 1'b0, j == 5, k1o, 1'b0, sr, si, se);
      else if (j < 13) w = ev(1'b1, 1'b0, j == 9, k1o, 1'b1, dr, di, de);
      else w = '0;
      chk(tag, w);
    end
  endtask
  initial begin
    logic [VW-1:0] w;
    int o;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("reset", '0);
    rst_sys = 1'b0;
    scen1("s1");
    run_m4("s2_rot", 100, 0, 0, 1'b0, 0, 50, 0, 1'b1, 150, 0, 0, 50, 0, 0, 1'b1);
    run_m4("s3_ovf", 32767, 0, 3, 1'b0, 32767, 0, 3, 1'b0, 32767, 0, 4, 0, 0, 3, 1'b0);
    run_m4("s4_align", 7, 0, 0, 1'b0, 0, 0, 2, 1'b0, 2, 0, 2, 2, 0, 2, 1'b0);
    run_m4("s4_round", -6, 0, 0, 1'b0, 0, 0, 2, 1'b0, -2, 0, 2, -2, 0, 2, 1'b0);
    ldn_rg_i = 4'd5;
    for (int n = 0; n < 42; n++) begin
      if (n < 32) drv(1'b1, n == 0, n == 0, 1'b0, n, 0, 0);
      else drv(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      o = n - 9;
      if (o >= 0 && o < 32)
        w = ev(1'b1, o == 0, o % 8 == 0, 1'b0, (o / 8) % 2 == 1, ((o / 8) % 2 == 1) ? -8 : 2 * o + 8, 0, 0);
      else w = '0;
      chk("s5_m8", w);
    end
    ldn_rg_i = 4'd4;
    for (int n = 0; n < 6; n++) drv(1'b1, n == 0, 1'b0, 1'b0, 100 * n, 0, 0);
    chk("s6_pre", ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 400, 0, 0));
    rst_sys = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("s6_rst", '0);
    rst_sys = 1'b0;
    scen1("s6");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
